// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad digit capture path.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    DB_REL
  } state_t;

  localparam logic [3:0] NO_KEY    = 4'd0;
  localparam logic [3:0] MAX_DIGIT = 4'd9;
  localparam logic [3:0] Y_IDLE_N  = 4'b1111;

  // Codes 10..15 can only come from a bad encoder state, so they read as no key.
  function automatic logic is_key(input logic [3:0] code);
    return (code != NO_KEY) && (code <= MAX_DIGIT);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus whose bits are treated as independent levels.
module sync_2ff #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_digit_capture.sv
// Debounces the encoder's key code, accepts each press once and shifts the
// accepted digit into a BCD entry buffer.
module keypad_digit_capture
  import keypad_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 Y_n,
  input  logic                       clr,
  output logic                       digit_valid,
  output logic [3:0]                 digit,
  output logic [4*DEPTH-1:0]         digits,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       ovf
);

  localparam int CNT_W   = $clog2(DB_CYCLES + 1);
  localparam int COUNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(DEPTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cand;
  logic [3:0]       y_sync;
  logic [3:0]       code;
  logic             key_valid;
  logic             push;
  logic [3:0]       push_val;
  logic [4*DEPTH-1:0] shifted;

  sync_2ff #(
    .WIDTH    (4),
    .RESET_VAL(Y_IDLE_N)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (Y_n),
    .q    (y_sync)
  );

  assign code      = ~y_sync;
  assign key_valid = is_key(code);
  assign full      = (count == COUNT_MAX);

  // With a single-cycle debounce the IDLE edge itself accepts the key, so the
  // pushed value must come straight from the code rather than the latched cand.
  always_comb begin
    push     = 1'b0;
    push_val = cand;
    case (state)
      IDLE: begin
        if (key_valid && (DB_CYCLES == 1)) begin
          push     = 1'b1;
          push_val = code;
        end
      end
      DB_PRESS: begin
        if ((code == cand) && (cnt == CNT_LAST)) begin
          push = 1'b1;
        end
      end
      default: ;
    endcase
  end

  generate
    if (DEPTH == 1) begin : g_single
      assign shifted = push_val;
    end else begin : g_shift
      assign shifted = {digits[4*DEPTH-5:0], push_val};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cand        <= NO_KEY;
      digit_valid <= 1'b0;
      digit       <= 4'd0;
      digits      <= '0;
      count       <= '0;
      ovf         <= 1'b0;
    end else begin
      digit_valid <= push;
      if (push) begin
        digit <= push_val;
      end

      // clr overrides a coincident push for the buffer but not for digit/digit_valid.
      if (clr) begin
        digits <= '0;
        count  <= '0;
        ovf    <= 1'b0;
      end else if (push) begin
        digits <= shifted;
        if (count == COUNT_MAX) begin
          ovf <= 1'b1;
        end else begin
          count <= count + COUNT_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (key_valid) begin
            cand  <= code;
            cnt   <= CNT_ONE;
            state <= push ? PRESSED : DB_PRESS;
          end
        end
        DB_PRESS: begin
          if (code == cand) begin
            if (cnt == CNT_LAST) begin
              state <= PRESSED;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            state <= IDLE;
          end
        end
        PRESSED: begin
          if (!key_valid) begin
            if (DB_CYCLES == 1) begin
              state <= IDLE;
            end else begin
              cnt   <= CNT_ONE;
              state <= DB_REL;
            end
          end
        end
        DB_REL: begin
          if (key_valid) begin
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
